// File: rtl/logic_gate_unit.sv
// rtl/logic_gate_unit.sv - bitwise op unit with OR accumulator and 2-entry result buffer
module logic_gate_unit #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [2:0]       in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_any,
   output logic             out_all,
   output logic [WIDTH-1:0] acc
);

   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] ONE   = 2'd1;
   localparam logic [1:0] FULL  = 2'd2;

   logic [1:0]       count_q, count_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] head_data_q, head_data_d;
   logic             head_any_q, head_any_d;
   logic             head_all_q, head_all_d;
   logic [WIDTH-1:0] tail_data_q, tail_data_d;
   logic             tail_any_q, tail_any_d;
   logic             tail_all_q, tail_all_d;

   logic [WIDTH-1:0] result;
   logic             res_any;
   logic             res_all;
   logic             push;
   logic             pop;

   assign in_ready  = (count_q != FULL);
   assign out_valid = (count_q != EMPTY);
   assign out_data  = head_data_q;
   assign out_any   = head_any_q;
   assign out_all   = head_all_q;
   assign acc       = acc_q;

   assign push = in_valid && in_ready;
   assign pop  = out_valid && out_ready;

   always_comb begin
      result = '0;
      acc_d  = acc_q;
      case (in_op)
         3'd0: result = in_a & in_b;
         3'd1: result = in_a | in_b;
         3'd2: result = in_a ^ in_b;
         3'd3: result = ~(in_a & in_b);
         3'd4: result = ~(in_a | in_b);
         3'd5: result = ~(in_a ^ in_b);
         3'd6: begin
            result = acc_q | in_a | in_b;
            if (push) acc_d = result;
         end
         default: begin
            result = acc_q;
            if (push) acc_d = '0;
         end
      endcase
      res_any = |result;
      res_all = &result;
   end

   // Head is a real register so it keeps its last value once the buffer drains.
   always_comb begin
      count_d     = count_q;
      head_data_d = head_data_q;
      head_any_d  = head_any_q;
      head_all_d  = head_all_q;
      tail_data_d = tail_data_q;
      tail_any_d  = tail_any_q;
      tail_all_d  = tail_all_q;
      case (count_q)
         EMPTY: begin
            if (push) begin
               head_data_d = result;
               head_any_d  = res_any;
               head_all_d  = res_all;
               count_d     = ONE;
            end
         end
         ONE: begin
            if (push && pop) begin
               head_data_d = result;
               head_any_d  = res_any;
               head_all_d  = res_all;
            end else if (push) begin
               tail_data_d = result;
               tail_any_d  = res_any;
               tail_all_d  = res_all;
               count_d     = FULL;
            end else if (pop) begin
               count_d = EMPTY;
            end
         end
         FULL: begin
            if (pop) begin
               head_data_d = tail_data_q;
               head_any_d  = tail_any_q;
               head_all_d  = tail_all_q;
               count_d     = ONE;
            end
         end
         default: count_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q     <= EMPTY;
         acc_q       <= '0;
         head_data_q <= '0;
         head_any_q  <= 1'b0;
         head_all_q  <= 1'b0;
         tail_data_q <= '0;
         tail_any_q  <= 1'b0;
         tail_all_q  <= 1'b0;
      end else begin
         count_q     <= count_d;
         acc_q       <= acc_d;
         head_data_q <= head_data_d;
         head_any_q  <= head_any_d;
         head_all_q  <= head_all_d;
         tail_data_q <= tail_data_d;
         tail_any_q  <= tail_any_d;
         tail_all_q  <= tail_all_d;
      end
   end

endmodule
